// File: rtl/layer_seq_pkg.sv
// -----------------------------------------------------------------------------
// layer_seq_pkg
// Shared definitions for the per-layer convolution sequencer:
//   - one-hot state encoding of the sequencer FSM
//   - cmd_reg0 op codes, target codes and field bit positions
//   - AXI-Stream source indices (bias, LeakyReLU, weight, feature)
//   - helpers that assemble cmd_reg0 words
// Used by layer_seq_ctrl and layer_seq_axis_mux.
// -----------------------------------------------------------------------------
package layer_seq_pkg;

  typedef enum logic [7:0] {
    ST_IDLE   = 8'b0000_0001,
    ST_BIAS   = 8'b0000_0010,
    ST_LRELU  = 8'b0000_0100,
    ST_WEIGHT = 8'b0000_1000,
    ST_FEAT   = 8'b0001_0000,
    ST_CONV   = 8'b0010_0000,
    ST_DMA_RX = 8'b0100_0000,
    ST_DONE   = 8'b1000_0000
  } state_t;

  // cmd_reg0 op nibble
  localparam logic [3:0] OP_NONE       = 4'h0;
  localparam logic [3:0] OP_TX_START   = 4'h1;
  localparam logic [3:0] OP_READ_START = 4'h2;
  localparam logic [3:0] OP_CONV_START = 4'h4;

  // cmd_reg0 target nibble
  localparam logic [3:0] TGT_WEIGHT = 4'h1;
  localparam logic [3:0] TGT_BIAS   = 4'h2;
  localparam logic [3:0] TGT_LRELU  = 4'h3;
  localparam logic [3:0] TGT_FEAT   = 4'h8;

  // cmd_reg0 field positions
  localparam int CMD_OP_LSB     = 0;
  localparam int CMD_TGT_LSB    = 4;
  localparam int CMD_FEAT_BIT   = 8;
  localparam int CMD_ROWPOS_LSB = 9;
  localparam int CMD_BATCH_LSB  = 12;
  localparam int CMD_FIXED_BIT  = 14;
  localparam int CMD_ROWS_LSB   = 16;

  // Row position codes
  localparam logic [1:0] ROWPOS_FIRST = 2'd0;
  localparam logic [1:0] ROWPOS_MID   = 2'd1;
  localparam logic [1:0] ROWPOS_LAST  = 2'd2;

  // Stream source indices
  localparam int         SRC_NUM    = 4;
  localparam logic [1:0] SRC_BIAS   = 2'd0;
  localparam logic [1:0] SRC_LRELU  = 2'd1;
  localparam logic [1:0] SRC_WEIGHT = 2'd2;
  localparam logic [1:0] SRC_FEAT   = 2'd3;

  // Load-phase command: only target and op are populated.
  function automatic logic [31:0] load_cmd(input logic [3:0] tgt);
    logic [31:0] v;
    v = '0;
    v[CMD_TGT_LSB +: 4] = tgt;
    v[CMD_OP_LSB +: 4]  = OP_TX_START;
    return v;
  endfunction

  // Feature-phase command (feature batches, convolution, readback).
  function automatic logic [31:0] feat_cmd(input logic [3:0] op,
                                           input logic [1:0] rowpos,
                                           input logic [1:0] batch,
                                           input logic [7:0] rows);
    logic [31:0] v;
    v = '0;
    v[CMD_ROWS_LSB +: 8]   = rows;
    v[CMD_FIXED_BIT]       = 1'b1;
    v[CMD_BATCH_LSB +: 2]  = batch;
    v[CMD_ROWPOS_LSB +: 2] = rowpos;
    v[CMD_FEAT_BIT]        = 1'b1;
    v[CMD_TGT_LSB +: 4]    = TGT_FEAT;
    v[CMD_OP_LSB +: 4]     = op;
    return v;
  endfunction

endpackage

// File: rtl/layer_seq_axis_mux.sv
// -----------------------------------------------------------------------------
// layer_seq_axis_mux
// 4:1 AXI-Stream multiplexer. When enabled, the selected source drives the
// output stream and receives the downstream ready; all other sources see
// ready low. When disabled the output stream is idle (valid/last/data = 0).
// tkeep is constant all-ones.
// Ports:
//   i_en           mux enable (a load or feature phase is active)
//   i_sel          selected source index
//   i_src_tdata    packed source data, source i at [i*DATA_W +: DATA_W]
//   i_src_tvalid   per-source valid
//   i_src_tlast    per-source last
//   o_src_tready   per-source ready
//   o_tdata/o_tkeep/o_tvalid/o_tlast  output stream
//   i_tready       output stream ready
// -----------------------------------------------------------------------------
module layer_seq_axis_mux
  import layer_seq_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic                      i_en,
  input  logic [1:0]                i_sel,
  input  logic [SRC_NUM*DATA_W-1:0] i_src_tdata,
  input  logic [SRC_NUM-1:0]        i_src_tvalid,
  input  logic [SRC_NUM-1:0]        i_src_tlast,
  output logic [SRC_NUM-1:0]        o_src_tready,
  output logic [DATA_W-1:0]         o_tdata,
  output logic [DATA_W/8-1:0]       o_tkeep,
  output logic                      o_tvalid,
  output logic                      o_tlast,
  input  logic                      i_tready
);

  assign o_tkeep = '1;

  always_comb begin
    o_tdata      = '0;
    o_tvalid     = 1'b0;
    o_tlast      = 1'b0;
    o_src_tready = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      if (i_en && (i_sel == 2'(i))) begin
        o_tdata         = i_src_tdata[i*DATA_W +: DATA_W];
        o_tvalid        = i_src_tvalid[i];
        o_tlast         = i_src_tlast[i];
        o_src_tready[i] = i_tready;
      end
    end
  end

endmodule

// File: rtl/layer_seq_ctrl.sv
// -----------------------------------------------------------------------------
// layer_seq_ctrl
// Per-layer sequencer for the convolution accelerator. Walks the load phases
// (bias, LeakyReLU table, weights), then for every row block iterates the
// feature batches and convolutions and finishes with a DMA readback. Each
// phase is started by writing cmd_reg0 with a nonzero op nibble for exactly
// one cycle; task_finish from the accelerator advances the sequence.
//
// Optional build macro: LAYER_SEQ_TIMEOUT_EN
//   defined   - a 16-bit wait counter aborts any waiting state after
//               TIMEOUT_CYC cycles, sets sticky err_timeout, returns to IDLE.
//   undefined - no counter; err_timeout is constant 0.
//
// Ports:
//   sclk, s_rst           clock, synchronous active-high reset
//   start                 one-cycle layer start (ignored while busy)
//   cfg_pix_num, cfg_geom layer configuration, latched on start
//   task_finish           accelerator phase-complete pulse
//   cmd_reg0..2           command registers
//   src_tdata/tvalid/tlast/tready  four stream sources (bias, lrelu, weight, feature)
//   src_rst               per-source generator reset
//   m_axis_*              muxed MM2S stream
//   busy, done            layer in progress / one-cycle end-of-layer pulse
//   err_timeout           sticky watchdog error
//   tx_cnt, batch_cnt     current row block and feature batch
// -----------------------------------------------------------------------------
module layer_seq_ctrl
  import layer_seq_pkg::*;
#(
  parameter int         DATA_W      = 64,
  parameter int         BATCH_NUM   = 2,
  parameter int         ROW_BLK_NUM = 13,
  parameter logic [7:0] MID_ROWS    = 8'h24,
  parameter logic [7:0] LAST_ROWS   = 8'h06,
  parameter int         TIMEOUT_CYC = 65535
) (
  input  logic                  sclk,
  input  logic                  s_rst,
  input  logic                  start,
  input  logic [15:0]           cfg_pix_num,
  input  logic [31:0]           cfg_geom,
  input  logic                  task_finish,
  output logic [31:0]           cmd_reg0,
  output logic [31:0]           cmd_reg1,
  output logic [31:0]           cmd_reg2,
  input  logic [4*DATA_W-1:0]   src_tdata,
  input  logic [3:0]            src_tvalid,
  input  logic [3:0]            src_tlast,
  output logic [3:0]            src_tready,
  output logic [3:0]            src_rst,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  done,
  output logic                  err_timeout,
  output logic [7:0]            tx_cnt,
  output logic [1:0]            batch_cnt
);

  localparam logic [1:0] LAST_BATCH = 2'(BATCH_NUM - 1);
  localparam logic [7:0] LAST_BLK   = 8'(ROW_BLK_NUM - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_cmd0, r_cmd1, r_cmd2;
  logic [31:0] w_cmd0_nxt, w_cmd1_nxt;
  logic [15:0] r_pix_num;
  logic [7:0]  r_tx_cnt, w_tx_nxt;
  logic [1:0]  r_batch_cnt, w_batch_nxt;
  logic        w_start_acc;
  logic        w_wd_hit;
  logic        w_waiting;
  logic        w_feat_phase;
  logic        w_mux_en;
  logic [1:0]  w_mux_sel;

  function automatic logic [1:0] row_pos(input logic [7:0] t);
    if (t == 8'd0)     return ROWPOS_FIRST;
    if (t == LAST_BLK) return ROWPOS_LAST;
    return ROWPOS_MID;
  endfunction

  function automatic logic [31:0] feat_word(input logic [3:0] op,
                                            input logic [7:0] t,
                                            input logic [1:0] b);
    logic [1:0] rp;
    rp = row_pos(t);
    return feat_cmd(op, rp, b, (rp == ROWPOS_LAST) ? LAST_ROWS : MID_ROWS);
  endfunction

  assign w_waiting = r_state inside {ST_BIAS, ST_LRELU, ST_WEIGHT,
                                     ST_FEAT, ST_CONV, ST_DMA_RX};

  // Next state and next command words. The op nibble defaults to zero so it
  // is nonzero only in the first cycle after a transition writes it.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd0_nxt  = r_cmd0;
    w_cmd0_nxt[CMD_OP_LSB +: 4] = OP_NONE;
    w_cmd1_nxt  = r_cmd1;
    w_tx_nxt    = r_tx_cnt;
    w_batch_nxt = r_batch_cnt;
    w_start_acc = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_state_nxt = ST_BIAS;
          w_cmd0_nxt  = load_cmd(TGT_BIAS);
        end
      end
      ST_BIAS: begin
        if (task_finish) begin
          w_state_nxt = ST_LRELU;
          w_cmd0_nxt  = load_cmd(TGT_LRELU);
        end
      end
      ST_LRELU: begin
        if (task_finish) begin
          w_state_nxt = ST_WEIGHT;
          w_cmd0_nxt  = load_cmd(TGT_WEIGHT);
        end
      end
      ST_WEIGHT: begin
        if (task_finish) begin
          w_state_nxt = ST_FEAT;
          w_tx_nxt    = 8'd0;
          w_batch_nxt = 2'd0;
          w_cmd0_nxt  = feat_word(OP_TX_START, 8'd0, 2'd0);
        end
      end
      ST_FEAT: begin
        if (task_finish) begin
          w_state_nxt = ST_CONV;
          w_cmd0_nxt  = feat_word(OP_CONV_START, r_tx_cnt, r_batch_cnt);
          w_cmd1_nxt  = {r_pix_num, 8'h00, 6'b0, r_batch_cnt};
        end
      end
      ST_CONV: begin
        if (task_finish) begin
          if (r_batch_cnt != LAST_BATCH) begin
            w_state_nxt = ST_FEAT;
            w_batch_nxt = r_batch_cnt + 2'd1;
            w_cmd0_nxt  = feat_word(OP_TX_START, r_tx_cnt, r_batch_cnt + 2'd1);
          end else begin
            w_state_nxt = ST_DMA_RX;
            w_batch_nxt = 2'd0;
            w_cmd0_nxt  = feat_word(OP_READ_START, r_tx_cnt, 2'd0);
          end
        end
      end
      ST_DMA_RX: begin
        if (task_finish) begin
          if (r_tx_cnt != LAST_BLK) begin
            w_state_nxt = ST_FEAT;
            w_tx_nxt    = r_tx_cnt + 8'd1;
            w_batch_nxt = 2'd0;
            w_cmd0_nxt  = feat_word(OP_TX_START, r_tx_cnt + 8'd1, 2'd0);
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 8'd0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Watchdog abort takes priority over a same-cycle task_finish.
    if (w_wd_hit) begin
      w_state_nxt = ST_IDLE;
      w_cmd0_nxt  = r_cmd0;
      w_cmd0_nxt[CMD_OP_LSB +: 4] = OP_NONE;
      w_cmd1_nxt  = r_cmd1;
      w_tx_nxt    = r_tx_cnt;
      w_batch_nxt = r_batch_cnt;
    end
  end

  always_ff @(posedge sclk) begin
    if (s_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      r_cmd0      <= '0;
      r_cmd1      <= '0;
      r_cmd2      <= '0;
      r_pix_num   <= '0;
      r_tx_cnt    <= '0;
      r_batch_cnt <= '0;
    end else begin
      r_cmd0      <= w_cmd0_nxt;
      r_cmd1      <= w_cmd1_nxt;
      r_tx_cnt    <= w_tx_nxt;
      r_batch_cnt <= w_batch_nxt;
      if (w_start_acc) begin
        r_cmd2    <= cfg_geom;
        r_pix_num <= cfg_pix_num;
      end
    end
  end

`ifdef LAYER_SEQ_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] r_wait_cnt;
  logic        r_err;

  // Cleared on every state change, so it measures time spent in the current
  // state only. Reaching WD_LAST means the next edge is TIMEOUT_CYC cycles
  // after entry.
  always_ff @(posedge sclk) begin
    if (s_rst)                       r_wait_cnt <= '0;
    else if (w_state_nxt != r_state) r_wait_cnt <= '0;
    else if (w_waiting)              r_wait_cnt <= r_wait_cnt + 16'd1;
  end

  assign w_wd_hit = w_waiting && (r_wait_cnt == WD_LAST);

  always_ff @(posedge sclk) begin
    if (s_rst)            r_err <= 1'b0;
    else if (w_wd_hit)    r_err <= 1'b1;
    else if (w_start_acc) r_err <= 1'b0;
  end

  assign err_timeout = r_err;
`else
  // Watchdog not built: never fires for any legal (non-negative) limit.
  assign w_wd_hit    = (TIMEOUT_CYC < 0);
  assign err_timeout = 1'b0;
`endif

  assign cmd_reg0  = r_cmd0;
  assign cmd_reg1  = r_cmd1;
  assign cmd_reg2  = r_cmd2;
  assign tx_cnt    = r_tx_cnt;
  assign batch_cnt = r_batch_cnt;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);

  // The feature generator stays live across the whole row-block loop.
  assign w_feat_phase = r_state inside {ST_FEAT, ST_CONV, ST_DMA_RX};
  assign src_rst = {s_rst | ~w_feat_phase,
                    s_rst | (r_state != ST_WEIGHT),
                    s_rst | (r_state != ST_LRELU),
                    s_rst | (r_state != ST_BIAS)};

  always_comb begin
    w_mux_en  = 1'b1;
    w_mux_sel = SRC_BIAS;
    unique case (r_state)
      ST_BIAS:   w_mux_sel = SRC_BIAS;
      ST_LRELU:  w_mux_sel = SRC_LRELU;
      ST_WEIGHT: w_mux_sel = SRC_WEIGHT;
      ST_FEAT:   w_mux_sel = SRC_FEAT;
      default:   w_mux_en  = 1'b0;
    endcase
  end

  layer_seq_axis_mux #(
    .DATA_W (DATA_W)
  ) u_axis_mux (
    .i_en         (w_mux_en),
    .i_sel        (w_mux_sel),
    .i_src_tdata  (src_tdata),
    .i_src_tvalid (src_tvalid),
    .i_src_tlast  (src_tlast),
    .o_src_tready (src_tready),
    .o_tdata      (m_axis_tdata),
    .o_tkeep      (m_axis_tkeep),
    .o_tvalid     (m_axis_tvalid),
    .o_tlast      (m_axis_tlast),
    .i_tready     (m_axis_tready)
  );

endmodule
